// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg -- shared definitions for the multi-slave SPI master.
//
// Contents:
//   spi_state_e     transfer FSM states (IDLE, SETUP, XFER, HOLD, DONE)
//   MODE_CPOL_BIT   bit position of CPOL inside the 2-bit mode field
//   MODE_CPHA_BIT   bit position of CPHA inside the 2-bit mode field
//   sel_w()         width of the slave-select index for a given slave count
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    localparam int MODE_CPOL_BIT = 1;
    localparam int MODE_CPHA_BIT = 0;

    // A single slave still needs a 1-bit select port.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen -- half-period divider and sclk level generator.
//
// Ports:
//   clk       system clock (rising edge)
//   reset     synchronous active-high reset; forces sclk low
//   load      transfer accepted: preload counter with div, park sclk at cpol
//   run       count while a transfer is active (SETUP/XFER/HOLD)
//   toggle    sclk toggles on each strobe while high (XFER only)
//   div       half-period reload value (half-period = div+1 clk cycles)
//   cpol      idle level of sclk, taken on load
//   edge_stb  one-cycle strobe marking the end of each half-period
//   sclk      serial clock level
// ---------------------------------------------------------------------------
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic             toggle,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    output logic             edge_stb,
    output logic             sclk
);

    logic [DIV_W-1:0] cnt;

    assign edge_stb = run && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            // Reload at every half-period boundary so clk_div=0 strobes every cycle.
            if (load || edge_stb) begin
                cnt <= div;
            end else if (run) begin
                cnt <= cnt - 1'b1;
            end

            if (load) begin
                sclk <= cpol;
            end else if (edge_stb && toggle) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/spi_master_nslv.sv
// ---------------------------------------------------------------------------
// spi_master_nslv -- SPI master with NUM_SLV one-hot chip-selects, runtime
// mode {CPOL,CPHA} and runtime sclk divider.
//
// Optional feature: define SPI_LSB_FIRST_EN to add the lsb_first input,
// latched at start, selecting LSB-first shifting for tx and rx. Without it
// frames are MSB-first only and the port is absent.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             one-cycle transfer request (honoured only in IDLE)
//   slv_sel           target slave index; out-of-range pulses err
//   mode              {CPOL, CPHA}
//   clk_div           sclk half-period = clk_div+1 clk cycles
//   tx_data           frame to send
//   lsb_first         (SPI_LSB_FIRST_EN only) LSB-first frame order
//   rx_data           last received frame, updated on entry to DONE
//   busy              high in SETUP, XFER, HOLD
//   done              one-cycle completion pulse (DONE state)
//   err               one-cycle pulse for a rejected start
//   sclk, mosi, miso  serial bus
//   cs_n              active-low one-hot chip-selects
// ---------------------------------------------------------------------------
module spi_master_nslv
    import spi_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NUM_SLV = 3,
    parameter  int DIV_W   = 8,
    localparam int SEL_W   = spi_pkg::sel_w(NUM_SLV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEL_W-1:0]  slv_sel,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SLV-1:0] cs_n
);

    localparam int                EC_W      = $clog2(2 * DATA_W);
    localparam logic [EC_W-1:0]   LAST_EDGE = EC_W'(2 * DATA_W - 1);
    localparam logic [31:0]       NUM_SLV_U = 32'(NUM_SLV);

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b,
                                                   input logic lsb);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    spi_state_e        state, state_nxt;
    logic [SEL_W-1:0]  sel_q;
    logic              cpha_q;
    logic [DIV_W-1:0]  div_q;
    logic              lsb_q;
    logic              lsb_in;
    logic [EC_W-1:0]   edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;

    logic              sel_ok;
    logic              accept;
    logic              reject;
    logic              active;
    logic              sclk_edge;
    logic              xfer_edge;
    logic              launch;
    logic              sample;
    logic              last_edge;
    logic [DIV_W-1:0]  div_src;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    assign sel_ok    = (32'(slv_sel) < NUM_SLV_U);
    assign accept    = (state == IDLE) && start && sel_ok;
    assign reject    = (state == IDLE) && start && !sel_ok;
    assign active    = (state == SETUP) || (state == XFER) || (state == HOLD);
    assign xfer_edge = (state == XFER) && sclk_edge;
    // Edges are numbered from 1: edge_cnt even means an odd edge.
    // CPHA=0 launches on even edges, CPHA=1 on odd edges; the rest sample.
    assign launch    = xfer_edge && (edge_cnt[0] ^ cpha_q);
    assign sample    = xfer_edge && !launch;
    assign last_edge = (edge_cnt == LAST_EDGE);
    // The divider must see the new clk_div in the same cycle it is latched.
    assign div_src   = accept ? clk_div : div_q;

    spi_clk_gen #(
        .DIV_W(DIV_W)
    ) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .run      (active),
        .toggle   (state == XFER),
        .div      (div_src),
        .cpol     (mode[MODE_CPOL_BIT]),
        .edge_stb (sclk_edge),
        .sclk     (sclk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = active;
        done      = (state == DONE);
        cs_n      = '1;

        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (sclk_edge) state_nxt = XFER;
            XFER:    if (sclk_edge && last_edge) state_nxt = HOLD;
            HOLD:    if (sclk_edge) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (active) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                if (sel_q == SEL_W'(i)) cs_n[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q    <= '0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            lsb_q    <= 1'b0;
            edge_cnt <= '0;
            err      <= 1'b0;
            mosi     <= 1'b0;
            rx_data  <= '0;
        end else begin
            err <= reject;

            if (accept) begin
                sel_q    <= slv_sel;
                cpha_q   <= mode[MODE_CPHA_BIT];
                div_q    <= clk_div;
                lsb_q    <= lsb_in;
                edge_cnt <= '0;
                // CPHA=0 presents the first bit before any sclk edge.
                if (!mode[MODE_CPHA_BIT]) mosi <= first_bit(tx_data, lsb_in);
            end

            if (xfer_edge) edge_cnt <= edge_cnt + 1'b1;
            if (launch)    mosi     <= first_bit(tx_sh, lsb_q);

            if ((state == HOLD) && sclk_edge) rx_data <= rx_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_sh <= mode[MODE_CPHA_BIT] ? tx_data : shift_out(tx_data, lsb_in);
        end else if (launch) begin
            tx_sh <= shift_out(tx_sh, lsb_q);
        end

        if (sample) rx_sh <= shift_in(rx_sh, miso, lsb_q);
    end

endmodule

// File: tb/tb_spi_master_nslv.sv
module tb_spi_master_nslv;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] slv_sel;
    logic [1:0] mode;
    logic [7:0] clk_div;
    logic [7:0] tx_data;
    logic       lsb_first;
    logic [7:0] rx_data;
    logic       busy, done, err, sclk, mosi, miso;
    logic [2:0] cs_n;

    logic        d16_start;
    logic [0:0]  d16_sel;
    logic [1:0]  d16_mode;
    logic [7:0]  d16_div;
    logic [15:0] d16_tx, d16_rx;
    logic        d16_busy, d16_done, d16_err, d16_sclk, d16_mosi, d16_miso;
    logic [0:0]  d16_cs_n;

    always #5 clk = ~clk;

    spi_master_nslv #(.DATA_W(8), .NUM_SLV(3), .DIV_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .slv_sel(slv_sel), .mode(mode),
        .clk_div(clk_div), .tx_data(tx_data),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .rx_data(rx_data), .busy(busy), .done(done), .err(err), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_master_nslv #(.DATA_W(16), .NUM_SLV(1), .DIV_W(8)) u_dut16 (
        .clk(clk), .reset(reset), .start(d16_start), .slv_sel(d16_sel), .mode(d16_mode),
        .clk_div(d16_div), .tx_data(d16_tx),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first(1'b0),
`endif
        .rx_data(d16_rx), .busy(d16_busy), .done(d16_done), .err(d16_err), .sclk(d16_sclk),
        .mosi(d16_mosi), .miso(d16_miso), .cs_n(d16_cs_n)
    );

    assign d16_miso = 1'b1;

    // Behavioural SPI slave for the 8-bit DUT.
    logic [7:0] s_tx, s_sh, s_cap;
    logic [1:0] s_mode;
    logic       s_lsb;
    logic       s_prev_sel, s_prev_sclk;
    int         s_e;
    wire        s_sel_now = (cs_n != 3'b111);

    always @(negedge clk) begin
        if (s_sel_now && !s_prev_sel) begin
            s_e   <= 0;
            s_cap <= '0;
            if (!s_mode[0]) begin
                miso <= s_lsb ? s_tx[0] : s_tx[7];
                s_sh <= s_lsb ? (s_tx >> 1) : (s_tx << 1);
            end else begin
                s_sh <= s_tx;
            end
        end else if (s_sel_now && (sclk != s_prev_sclk)) begin
            s_e <= s_e + 1;
            if ((((s_e + 1) % 2) == 1) != s_mode[0]) begin
                s_cap <= s_lsb ? {mosi, s_cap[7:1]} : {s_cap[6:0], mosi};
            end else begin
                miso <= s_lsb ? s_sh[0] : s_sh[7];
                s_sh <= s_lsb ? (s_sh >> 1) : (s_sh << 1);
            end
        end
        s_prev_sel  <= s_sel_now;
        s_prev_sclk <= sclk;
    end

    typedef struct {
        logic [1:0] mode;
        logic [7:0] div;
        logic [1:0] sel;
        logic [7:0] tx;
        logic [7:0] srx;
        logic       lsb;
    } vec_t;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] mosi_frame;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef SPI_LSB_FIRST_EN
    localparam logic LSB_T = 1'b1;
`else
    localparam logic LSB_T = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input vec_t v, input int inj_at);
        int         cyc;
        bit         got;
        bit         cs_bad;
        logic [2:0] exp_cs;
        exp_t       e;
        exp_cs        = 3'b111;
        exp_cs[v.sel] = 1'b0;
        s_tx      = v.srx;
        s_mode    = v.mode;
        s_lsb     = v.lsb;
        mode      = v.mode;
        clk_div   = v.div;
        slv_sel   = v.sel;
        tx_data   = v.tx;
        lsb_first = v.lsb;
        start     = 1'b1;
        sb.push_back('{rx: v.srx, mosi_frame: v.tx, lat: 18 * (int'(v.div) + 1) + 2});
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 2;
        if (!v.mode[0]) chk("first_mosi", {31'd0, mosi}, {31'd0, (v.lsb ? v.tx[0] : v.tx[7])});
        got    = 1'b0;
        cs_bad = 1'b0;
        while (!got && cyc < 2000) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (cs_n !== exp_cs || busy !== 1'b1) cs_bad = 1'b1;
                if (cyc == inj_at) begin
                    start   = 1'b1;
                    tx_data = 8'hFF;
                    slv_sel = 2'd0;
                    mode    = ~v.mode;
                end
                @(posedge clk); #1;
                if (start) begin
                    start = 1'b0;
                    chk("err_on_busy_start", {31'd0, err}, 32'd0);
                end
                cyc++;
            end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        if (got) begin
            e = sb.pop_front();
            chk("latency", cyc, e.lat);
            chk("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
            chk("mosi_frame", {24'd0, s_cap}, {24'd0, e.mosi_frame});
            chk("cs_busy_during", {31'd0, cs_bad}, 32'd0);
            chk("cs_in_done", {29'd0, cs_n}, 32'h7);
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("sclk_idle_cpol", {31'd0, sclk}, {31'd0, v.mode[1]});
        end else begin
            sb.delete();
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   n, guard, cyc;
        bit   got, saw_done;
        logic prev;

        vecs[0] = '{mode: 2'b00, div: 8'd1, sel: 2'd1, tx: 8'hA5, srx: 8'h3C, lsb: 1'b0};
        vecs[1] = '{mode: 2'b01, div: 8'd1, sel: 2'd1, tx: 8'hA5, srx: 8'h3C, lsb: 1'b0};
        vecs[2] = '{mode: 2'b10, div: 8'd1, sel: 2'd1, tx: 8'hA5, srx: 8'h3C, lsb: 1'b0};
        vecs[3] = '{mode: 2'b11, div: 8'd1, sel: 2'd1, tx: 8'hA5, srx: 8'h3C, lsb: 1'b0};
        vecs[4] = '{mode: 2'b00, div: 8'd0, sel: 2'd0, tx: 8'h5A, srx: 8'hC3, lsb: 1'b0};
        vecs[5] = '{mode: 2'b11, div: 8'd2, sel: 2'd2, tx: 8'h81, srx: 8'h7E, lsb: 1'b0};
        vecs[6] = '{mode: 2'b00, div: 8'd0, sel: 2'd2, tx: 8'h01, srx: 8'h96, lsb: LSB_T};
        vecs[7] = '{mode: 2'b10, div: 8'd3, sel: 2'd0, tx: 8'hFF, srx: 8'h00, lsb: 1'b0};

        reset     = 1'b1;
        start     = 1'b0;
        slv_sel   = '0;
        mode      = '0;
        clk_div   = '0;
        tx_data   = '0;
        lsb_first = 1'b0;
        s_tx      = '0;
        s_mode    = '0;
        s_lsb     = 1'b0;
        d16_start = 1'b0;
        d16_sel   = '0;
        d16_mode  = 2'b00;
        d16_div   = 8'd0;
        d16_tx    = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", {29'd0, cs_n}, 32'h7);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_rx", {24'd0, rx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst16_idle", {28'd0, d16_cs_n, d16_busy, d16_sclk, d16_mosi}, 32'h8);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) do_xfer(vecs[i], -1);

        // Out-of-range slave select.
        slv_sel = 2'd3;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_cs_n", {29'd0, cs_n}, 32'h7);
        chk("err_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("err_one_cycle", {31'd0, err}, 32'd0);
        chk("err_stays_idle", {31'd0, busy}, 32'd0);

        // Start pulsed mid-XFER must not disturb the running frame.
        do_xfer(vecs[0], 12);

        // 16-bit frame, clk_div=0.
        d16_start = 1'b1;
        @(posedge clk); #1;
        d16_start = 1'b0;
        cyc = 2;
        got = 1'b0;
        while (!got && cyc < 500) begin
            if (d16_done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("w16_done_seen", {31'd0, got}, 32'd1);
        chk("w16_latency", cyc, 32'd36);
        chk("w16_rx", {16'd0, d16_rx}, 32'hFFFF);
        chk("w16_err", {31'd0, d16_err}, 32'd0);

        // Reset at sclk edge 7 of a CPOL=1 transfer.
        s_tx    = 8'h55;
        s_mode  = 2'b10;
        s_lsb   = 1'b0;
        mode    = 2'b10;
        clk_div = 8'd1;
        slv_sel = 2'd2;
        tx_data = 8'h99;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        guard = 0;
        prev  = sclk;
        while (n < 7 && guard < 200) begin
            @(posedge clk); #1;
            if (sclk !== prev) n++;
            prev = sclk;
            guard++;
        end
        chk("abort_edge7_reached", n, 32'd7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_cs_n", {29'd0, cs_n}, 32'h7);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sclk", {31'd0, sclk}, 32'd0);
        chk("abort_mosi", {31'd0, mosi}, 32'd0);
        chk("abort_rx", {24'd0, rx_data}, 32'd0);
        saw_done = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        chk("abort_sclk_idle", {31'd0, sclk}, 32'd0);

        do_xfer(vecs[5], -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
